// File: rtl/wb_commit.sv
// Writeback/commit stage: selects and drives the RF write, keeps a registered copy of the last
// write for decode bypass, counts retired instructions and mispredicts, and halts on SYSTEM.
module wb_commit (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] aluResult_i,
    input  logic [31:0] memReadValue_i,
    input  logic [4:0]  rd_i,
    input  logic [6:0]  opcode_i,
    input  logic [11:0] pc_i,
    input  logic        isBtype_i,
    input  logic        bpr_i,
    input  logic        flush_i,
    output logic        rfWe_o,
    output logic [4:0]  rfWaddr_o,
    output logic [31:0] rfWdata_o,
    output logic        lastValid_o,
    output logic [4:0]  lastRd_o,
    output logic [31:0] lastData_o,
    output logic [31:0] retired_o,
    output logic [15:0] mispred_o,
    output logic        halt_o
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e      state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic [15:0] mispred_q, mispred_d;
    logic        last_valid_q, last_valid_d;
    logic [4:0]  last_rd_q, last_rd_d;
    logic [31:0] last_data_q, last_data_d;

    logic        slot_valid;
    logic        writes_rf;
    logic        rf_we;
    logic [31:0] wdata;

    always_comb begin
        slot_valid = !flush_i && (opcode_i != 7'h00);

        unique case (opcode_i)
            OpLoad:        wdata = memReadValue_i;
            OpJal, OpJalr: wdata = {20'b0, pc_i} + 32'd4;
            default:       wdata = aluResult_i;
        endcase

        unique case (opcode_i)
            OpR, OpIAlu, OpLoad, OpLui, OpAuipc, OpJal, OpJalr: writes_rf = 1'b1;
            default:                                           writes_rf = 1'b0;
        endcase

        // Reset masks the write so nothing commits to the RF during reset.
        rf_we = slot_valid && writes_rf && (rd_i != 5'd0) && (state_q == StRun) && !RST;
    end

    always_comb begin
        state_d      = state_q;
        retired_d    = retired_q;
        mispred_d    = mispred_q;
        last_valid_d = rf_we;
        last_rd_d    = rd_i;
        last_data_d  = wdata;

        if (state_q == StRun && slot_valid) begin
            retired_d = retired_q + 32'd1;
            if (isBtype_i && bpr_i && (mispred_q != 16'hFFFF)) begin
                mispred_d = mispred_q + 16'd1;
            end
            if (opcode_i == OpSystem) begin
                state_d = StHalted;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StRun;
            retired_q    <= 32'd0;
            mispred_q    <= 16'd0;
            last_valid_q <= 1'b0;
            last_rd_q    <= 5'd0;
            last_data_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            retired_q    <= retired_d;
            mispred_q    <= mispred_d;
            last_valid_q <= last_valid_d;
            last_rd_q    <= last_rd_d;
            last_data_q  <= last_data_d;
        end
    end

    assign rfWe_o      = rf_we;
    assign rfWaddr_o   = rd_i;
    assign rfWdata_o   = wdata;
    assign lastValid_o = last_valid_q;
    assign lastRd_o    = last_rd_q;
    assign lastData_o  = last_data_q;
    assign retired_o   = retired_q;
    assign mispred_o   = mispred_q;
    assign halt_o      = (state_q == StHalted);

endmodule
